// File: rtl/gbf_fill_scheduler_if.sv
// gbf_fill_scheduler_if: request, stream and gbf write-port bundle around the fill scheduler.
// The slave modport is the scheduler's view; master is the surrounding system's view.
interface gbf_fill_scheduler_if #(
  parameter int GBF_DATA_BITWIDTH = 256,
  parameter int GBF_ADDR_BITWIDTH = 5
);
  logic                         finish;
  logic                         actv_gbf1_need_data;
  logic                         actv_gbf2_need_data;
  logic                         wgt_gbf1_need_data;
  logic                         wgt_gbf2_need_data;
  logic                         req_valid;
  logic [1:0]                   req_id;
  logic                         req_ack;
  logic                         in_valid;
  logic [GBF_DATA_BITWIDTH-1:0] in_data;
  logic                         in_ready;
  logic                         actv_en1a;
  logic                         actv_we1a;
  logic                         actv_en2a;
  logic                         actv_we2a;
  logic                         wgt_en1a;
  logic                         wgt_we1a;
  logic                         wgt_en2a;
  logic                         wgt_we2a;
  logic [GBF_ADDR_BITWIDTH-1:0] gbf_w_addr;
  logic [GBF_DATA_BITWIDTH-1:0] gbf_w_data;
  logic                         gbf_actv_buf1_ready;
  logic                         gbf_actv_buf2_ready;
  logic                         gbf_wgt_buf1_ready;
  logic                         gbf_wgt_buf2_ready;
  logic                         gbf_actv_data_avail;
  logic                         gbf_wgt_data_avail;
  modport slave (
    input  finish, actv_gbf1_need_data, actv_gbf2_need_data, wgt_gbf1_need_data,
           wgt_gbf2_need_data, req_ack, in_valid, in_data,
    output req_valid, req_id, in_ready, actv_en1a, actv_we1a, actv_en2a, actv_we2a,
           wgt_en1a, wgt_we1a, wgt_en2a, wgt_we2a, gbf_w_addr, gbf_w_data,
           gbf_actv_buf1_ready, gbf_actv_buf2_ready, gbf_wgt_buf1_ready, gbf_wgt_buf2_ready,
           gbf_actv_data_avail, gbf_wgt_data_avail
  );
  modport master (
    output finish, actv_gbf1_need_data, actv_gbf2_need_data, wgt_gbf1_need_data,
           wgt_gbf2_need_data, req_ack, in_valid, in_data,
    input  req_valid, req_id, in_ready, actv_en1a, actv_we1a, actv_en2a, actv_we2a,
           wgt_en1a, wgt_we1a, wgt_en2a, wgt_we2a, gbf_w_addr, gbf_w_data,
           gbf_actv_buf1_ready, gbf_actv_buf2_ready, gbf_wgt_buf1_ready, gbf_wgt_buf2_ready,
           gbf_actv_data_avail, gbf_wgt_data_avail
  );
endinterface

// File: rtl/gbf_fill_scheduler.sv
// gbf_fill_scheduler: round-robin refill sequencer for the two actv and two wgt global buffers.
// Grants one need, issues a fetch request, streams GBF_DEPTH lines into that buffer's A-port, then signals ready.
module gbf_fill_scheduler #(
  parameter int GBF_DATA_BITWIDTH = 256,
  parameter int GBF_ADDR_BITWIDTH = 5,
  parameter int GBF_DEPTH         = 32
) (
  input logic clk,
  input logic rst_n,
  gbf_fill_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;
  state_t                       state_q, state_d;
  logic [1:0]                   sel_q, sel_d, rr_q, rr_d, grant;
  logic                         grant_vld;
  logic [3:0]                   need, elig, served_q, served_d, we_q, we_d, rdy_q, rdy_d;
  logic [GBF_ADDR_BITWIDTH-1:0] cnt_q, cnt_d, addr_q, addr_d;
  logic [GBF_DATA_BITWIDTH-1:0] data_q, data_d;
  logic                         req_valid_q, req_valid_d;
  logic                         actv_av_q, actv_av_d, wgt_av_q, wgt_av_d;
  assign need = {bus.wgt_gbf2_need_data, bus.wgt_gbf1_need_data,
                 bus.actv_gbf2_need_data, bus.actv_gbf1_need_data};
  assign elig = need & ~served_q;
  // Descending scan so the eligible index closest at/after rr_q wins.
  always_comb begin
    grant = rr_q;
    grant_vld = 1'b0;
    for (int k = 3; k >= 0; k--)
      if (elig[rr_q + 2'(k)]) begin
        grant = rr_q + 2'(k);
        grant_vld = 1'b1;
      end
  end
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    rr_d = rr_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    data_d = data_q;
    req_valid_d = req_valid_q;
    we_d = 4'b0;
    rdy_d = 4'b0;
    served_d = served_q & need;
    actv_av_d = actv_av_q;
    wgt_av_d = wgt_av_q;
    case (state_q)
      IDLE: if (grant_vld) begin
        sel_d = grant;
        req_valid_d = 1'b1;
        state_d = REQ;
      end
      REQ: if (bus.req_ack) begin
        req_valid_d = 1'b0;
        cnt_d = '0;
        state_d = FILL;
      end
      FILL: if (bus.in_valid) begin
        we_d = 4'b1 << sel_q;
        addr_d = cnt_q;
        data_d = bus.in_data;
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == GBF_ADDR_BITWIDTH'(GBF_DEPTH - 1)) ? DONE : FILL;
      end
      DONE: begin
        rdy_d = 4'b1 << sel_q;
        served_d = (served_q & need) | (4'b1 << sel_q);
        rr_d = sel_q + 2'd1;
        actv_av_d = actv_av_q | ~sel_q[1];
        wgt_av_d = wgt_av_q | sel_q[1];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides everything, including a beat accepted this same cycle.
    if (bus.finish) begin
      state_d = IDLE;
      req_valid_d = 1'b0;
      we_d = 4'b0;
      rdy_d = 4'b0;
      served_d = 4'b0;
      rr_d = 2'd0;
      cnt_d = '0;
      actv_av_d = 1'b0;
      wgt_av_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q <= '0;
      rr_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      req_valid_q <= 1'b0;
      we_q <= '0;
      rdy_q <= '0;
      served_q <= '0;
      actv_av_q <= 1'b0;
      wgt_av_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      rr_q <= rr_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      data_q <= data_d;
      req_valid_q <= req_valid_d;
      we_q <= we_d;
      rdy_q <= rdy_d;
      served_q <= served_d;
      actv_av_q <= actv_av_d;
      wgt_av_q <= wgt_av_d;
    end
  assign bus.req_valid = req_valid_q;
  assign bus.req_id = sel_q;
  assign bus.in_ready = state_q == FILL;
  assign {bus.wgt_en2a, bus.wgt_en1a, bus.actv_en2a, bus.actv_en1a} = we_q;
  assign {bus.wgt_we2a, bus.wgt_we1a, bus.actv_we2a, bus.actv_we1a} = we_q;
  assign bus.gbf_w_addr = addr_q;
  assign bus.gbf_w_data = data_q;
  assign {bus.gbf_wgt_buf2_ready, bus.gbf_wgt_buf1_ready,
          bus.gbf_actv_buf2_ready, bus.gbf_actv_buf1_ready} = rdy_q;
  assign bus.gbf_actv_data_avail = actv_av_q;
  assign bus.gbf_wgt_data_avail = wgt_av_q;
endmodule

// File: tb/tb_gbf_fill_scheduler.sv
// tb_gbf_fill_scheduler: scoreboard bench for the gbf fill scheduler.
// Expected A-port writes are queued as beats are driven and popped by a negedge monitor.
module tb_gbf_fill_scheduler;
  localparam int DW = 256;
  localparam int AW = 5;
  localparam int DEPTH = 32;
  typedef struct {
    logic [3:0]    oh;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [3:0] need_v = 4'b0;
  int pass_n = 0;
  int total_n = 0;
  int wr_cnt = 0;
  int rdy_cnt [4] = '{0, 0, 0, 0};
  wr_t exp_q [$];
  wr_t e_mon;
  always #5 clk = ~clk;
  gbf_fill_scheduler_if #(.GBF_DATA_BITWIDTH(DW), .GBF_ADDR_BITWIDTH(AW)) bus ();
  gbf_fill_scheduler #(.GBF_DATA_BITWIDTH(DW), .GBF_ADDR_BITWIDTH(AW), .GBF_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  assign {bus.wgt_gbf2_need_data, bus.wgt_gbf1_need_data,
          bus.actv_gbf2_need_data, bus.actv_gbf1_need_data} = need_v;
  wire [3:0] we_v = {bus.wgt_we2a, bus.wgt_we1a, bus.actv_we2a, bus.actv_we1a};
  wire [3:0] en_v = {bus.wgt_en2a, bus.wgt_en1a, bus.actv_en2a, bus.actv_en1a};
  wire [3:0] rdy_v = {bus.gbf_wgt_buf2_ready, bus.gbf_wgt_buf1_ready,
                      bus.gbf_actv_buf2_ready, bus.gbf_actv_buf1_ready};

  always @(negedge clk) begin
    if (we_v != 4'b0 || en_v != 4'b0) begin
      total_n++;
      wr_cnt++;
      if (exp_q.size() == 0)
        $display("FAIL write_unexpected: en=%b we=%b addr=%0d, required no write", en_v, we_v, bus.gbf_w_addr);
      else begin
        e_mon = exp_q.pop_front();
        if ({en_v, we_v, bus.gbf_w_addr, bus.gbf_w_data} !== {e_mon.oh, e_mon.oh, e_mon.addr, e_mon.data})
          $display("FAIL write: en=%b we=%b addr=%0d data=%h, required en=we=%b addr=%0d data=%h",
                   en_v, we_v, bus.gbf_w_addr, bus.gbf_w_data, e_mon.oh, e_mon.addr, e_mon.data);
        else pass_n++;
      end
    end
    for (int i = 0; i < 4; i++) if (rdy_v[i]) rdy_cnt[i]++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drives one fill for buffer idx; abort_at >= 0 asserts finish together with that beat.
  task automatic run_fill(input logic [1:0] idx, input bit stall, input int abort_at);
    int n;
    int k;
    int c;
    bit v;
    bit ready_ok;
    wr_t w;
    n = 0;
    while (bus.req_valid !== 1'b1 && n < 64) begin
      cyc();
      n++;
    end
    total_n++;
    if (bus.req_valid !== 1'b1 || bus.req_id !== idx)
      $display("FAIL grant: req_valid=%b req_id=%0d, required 1/%0d", bus.req_valid, bus.req_id, idx);
    else pass_n++;
    cyc();
    cyc();
    total_n++;
    if (bus.req_valid !== 1'b1 || bus.req_id !== idx || bus.in_ready !== 1'b0)
      $display("FAIL req_hold: req_valid=%b req_id=%0d in_ready=%b, required 1/%0d/0",
               bus.req_valid, bus.req_id, bus.in_ready, idx);
    else pass_n++;
    bus.req_ack = 1'b1;
    cyc();
    bus.req_ack = 1'b0;
    total_n++;
    if (bus.req_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL req_accept: req_valid=%b in_ready=%b, required 0/1", bus.req_valid, bus.in_ready);
    else pass_n++;
    k = 0;
    c = 0;
    ready_ok = 1'b1;
    while (k < DEPTH && c < 400) begin
      v = stall ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
      bus.in_valid = v;
      bus.in_data = rnd();
      if (bus.in_ready !== 1'b1) ready_ok = 1'b0;
      if (v && k == abort_at) begin
        bus.finish = 1'b1;
        need_v[idx] = 1'b0;
      end else if (v) begin
        w.oh = 4'b1 << idx;
        w.addr = AW'(k);
        w.data = bus.in_data;
        exp_q.push_back(w);
      end
      cyc();
      c++;
      if (bus.finish) begin
        bus.finish = 1'b0;
        bus.in_valid = 1'b0;
        return;
      end
      if (v) k++;
    end
    bus.in_valid = 1'b0;
    total_n++;
    if (k != DEPTH || !ready_ok)
      $display("FAIL stream: beats=%0d in_ready_held=%b, required %0d/1", k, ready_ok, DEPTH);
    else pass_n++;
    total_n++;
    if (bus.in_ready !== 1'b0 || rdy_v !== 4'b0)
      $display("FAIL done_cycle: in_ready=%b ready=%b, required 0/0000", bus.in_ready, rdy_v);
    else pass_n++;
    cyc();
    total_n++;
    if (rdy_v !== (4'b1 << idx) || (idx[1] ? bus.gbf_wgt_data_avail : bus.gbf_actv_data_avail) !== 1'b1)
      $display("FAIL ready_pulse: ready=%b actv_avail=%b wgt_avail=%b, required ready=%b avail for idx %0d",
               rdy_v, bus.gbf_actv_data_avail, bus.gbf_wgt_data_avail, 4'b1 << idx, idx);
    else pass_n++;
    cyc();
    total_n++;
    if (rdy_v !== 4'b0)
      $display("FAIL ready_width: ready=%b, required 0000", rdy_v);
    else pass_n++;
  endtask

  task automatic test_reset();
    bus.finish = 1'b0;
    bus.req_ack = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    #1 rst_n = 1'b0;
    cyc();
    cyc();
    total_n++;
    if (bus.req_valid !== 1'b0 || bus.req_id !== 2'd0 || bus.in_ready !== 1'b0)
      $display("FAIL reset_req: req_valid=%b req_id=%0d in_ready=%b, required 0", bus.req_valid, bus.req_id, bus.in_ready);
    else pass_n++;
    total_n++;
    if (we_v !== 4'b0 || en_v !== 4'b0 || bus.gbf_w_addr !== '0 || bus.gbf_w_data !== '0)
      $display("FAIL reset_port: en=%b we=%b addr=%0d data=%h, required 0", en_v, we_v, bus.gbf_w_addr, bus.gbf_w_data);
    else pass_n++;
    total_n++;
    if (rdy_v !== 4'b0 || bus.gbf_actv_data_avail !== 1'b0 || bus.gbf_wgt_data_avail !== 1'b0)
      $display("FAIL reset_status: ready=%b avail=%b%b, required 0", rdy_v, bus.gbf_actv_data_avail, bus.gbf_wgt_data_avail);
    else pass_n++;
    #2 rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_round_robin();
    need_v = 4'hF;
    for (int i = 0; i < 4; i++) begin
      run_fill(2'(i), 1'b0, -1);
      need_v[i] = 1'b0;
    end
    need_v[1] = 1'b1;
    run_fill(2'd1, 1'b0, -1);
    need_v[1] = 1'b0;
    need_v = 4'b1001;
    run_fill(2'd3, 1'b0, -1);
    need_v[3] = 1'b0;
    run_fill(2'd0, 1'b0, -1);
    need_v[0] = 1'b0;
    cyc();
  endtask

  task automatic test_single();
    int base;
    int r0;
    base = wr_cnt;
    r0 = rdy_cnt[0];
    need_v[0] = 1'b1;
    run_fill(2'd0, 1'b0, -1);
    need_v[0] = 1'b0;
    repeat (3) cyc();
    total_n++;
    if (wr_cnt - base != DEPTH || rdy_cnt[0] - r0 != 1 || exp_q.size() != 0)
      $display("FAIL single_count: writes=%0d pulses=%0d pending=%0d, required %0d/1/0",
               wr_cnt - base, rdy_cnt[0] - r0, exp_q.size(), DEPTH);
    else pass_n++;
    total_n++;
    if (bus.gbf_actv_data_avail !== 1'b1)
      $display("FAIL single_avail: actv_avail=%b, required 1", bus.gbf_actv_data_avail);
    else pass_n++;
  endtask

  task automatic test_stale();
    int r3;
    bit regrant;
    r3 = rdy_cnt[3];
    regrant = 1'b0;
    need_v[3] = 1'b1;
    run_fill(2'd3, 1'b0, -1);
    repeat (8) begin
      cyc();
      if (bus.req_valid !== 1'b0) regrant = 1'b1;
    end
    total_n++;
    if (regrant)
      $display("FAIL stale_regrant: req_valid rose while need stayed high, required 0");
    else pass_n++;
    need_v[3] = 1'b0;
    cyc();
    need_v[3] = 1'b1;
    run_fill(2'd3, 1'b0, -1);
    need_v[3] = 1'b0;
    cyc();
    total_n++;
    if (rdy_cnt[3] - r3 != 2 || bus.gbf_wgt_data_avail !== 1'b1)
      $display("FAIL stale_pulses: pulses=%0d wgt_avail=%b, required 2/1", rdy_cnt[3] - r3, bus.gbf_wgt_data_avail);
    else pass_n++;
  endtask

  task automatic test_stall();
    int base;
    base = wr_cnt;
    need_v[2] = 1'b1;
    run_fill(2'd2, 1'b1, -1);
    need_v[2] = 1'b0;
    cyc();
    total_n++;
    if (wr_cnt - base != DEPTH || exp_q.size() != 0)
      $display("FAIL stall_writes: writes=%0d pending=%0d, required %0d/0", wr_cnt - base, exp_q.size(), DEPTH);
    else pass_n++;
  endtask

  task automatic test_finish();
    int base;
    int r2;
    base = wr_cnt;
    r2 = rdy_cnt[2];
    need_v[2] = 1'b1;
    run_fill(2'd2, 1'b0, 10);
    total_n++;
    if (bus.in_ready !== 1'b0 || bus.req_valid !== 1'b0 ||
        bus.gbf_actv_data_avail !== 1'b0 || bus.gbf_wgt_data_avail !== 1'b0)
      $display("FAIL finish_state: in_ready=%b req_valid=%b avail=%b%b, required 0",
               bus.in_ready, bus.req_valid, bus.gbf_actv_data_avail, bus.gbf_wgt_data_avail);
    else pass_n++;
    bus.in_valid = 1'b1;
    repeat (4) cyc();
    bus.in_valid = 1'b0;
    total_n++;
    if (wr_cnt - base != 10 || rdy_cnt[2] != r2 || exp_q.size() != 0)
      $display("FAIL finish_writes: writes=%0d pulses=%0d pending=%0d, required 10/0/0",
               wr_cnt - base, rdy_cnt[2] - r2, exp_q.size());
    else pass_n++;
    need_v = 4'b1001;
    run_fill(2'd0, 1'b0, -1);
    need_v[0] = 1'b0;
    run_fill(2'd3, 1'b0, -1);
    need_v[3] = 1'b0;
    cyc();
  endtask

  task automatic test_async_reset();
    int n;
    n = 0;
    need_v[1] = 1'b1;
    while (bus.req_valid !== 1'b1 && n < 64) begin
      cyc();
      n++;
    end
    total_n++;
    if (bus.req_valid !== 1'b1 || bus.req_id !== 2'd1)
      $display("FAIL areset_grant: req_valid=%b req_id=%0d, required 1/1", bus.req_valid, bus.req_id);
    else pass_n++;
    #3 rst_n = 1'b0;
    #1;
    total_n++;
    if (bus.req_valid !== 1'b0 || bus.req_id !== 2'd0 ||
        bus.gbf_actv_data_avail !== 1'b0 || bus.gbf_wgt_data_avail !== 1'b0)
      $display("FAIL areset_now: req_valid=%b req_id=%0d avail=%b%b, required 0",
               bus.req_valid, bus.req_id, bus.gbf_actv_data_avail, bus.gbf_wgt_data_avail);
    else pass_n++;
    cyc();
    cyc();
    #2 rst_n = 1'b1;
    run_fill(2'd1, 1'b0, -1);
    need_v[1] = 1'b0;
    repeat (2) cyc();
    total_n++;
    if (exp_q.size() != 0)
      $display("FAIL final_pending: %0d writes outstanding, required 0", exp_q.size());
    else pass_n++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_stale();
    test_stall();
    test_finish();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/gbf_fill_scheduler.md
Name: gbf_fill_scheduler

Overview:
- Sequences refills of the four activation/weight global buffers in front of the PE array: actv gbf1/2 and wgt gbf1/2.
- Arbitrates the four need_data requests round-robin and issues a fetch request to the off-chip side.
- Streams GBF_DEPTH lines from a valid/ready input into the selected buffer's A-port, then pulses that buffer's ready line and raises data_avail.

Parameters:
- GBF_DATA_BITWIDTH, 256, width of one gbf line and of the input stream.
- GBF_ADDR_BITWIDTH, 5, gbf address width.
- GBF_DEPTH, 32, lines per buffer fill; must be ≤ 2^GBF_ADDR_BITWIDTH.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset (reset==0 resets all state).
- finish  input  1  end of layer; synchronous abort/clear.
- actv_gbf1_need_data, actv_gbf2_need_data, wgt_gbf1_need_data, wgt_gbf2_need_data  input  1 each  level requests; request index 0..3 in this order.
- req_valid  output  1  fetch request to off-chip side.
- req_id  output  2  buffer index being fetched.
- req_ack  input  1  fetch request accepted.
- in_valid  input  1  stream beat valid.
- in_data  input  GBF_DATA_BITWIDTH  stream beat.
- in_ready  output  1  scheduler accepts beat.
- actv_en1a/actv_we1a, actv_en2a/actv_we2a, wgt_en1a/wgt_we1a, wgt_en2a/wgt_we2a  output  1 each  port-A enable/write; en==we always.
- gbf_w_addr  output  GBF_ADDR_BITWIDTH  shared write address for all four A-ports.
- gbf_w_data  output  GBF_DATA_BITWIDTH  shared write data.
- gbf_actv_buf1_ready, gbf_actv_buf2_ready, gbf_wgt_buf1_ready, gbf_wgt_buf2_ready  output  1 each  one-cycle fill-complete pulses.
- gbf_actv_data_avail, gbf_wgt_data_avail  output  1 each  level outputs.

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_ptr=0; served[3:0]=0; beat counter 0.
- eligible[i] = need[i] & ~served[i].
- served[i] clears in any cycle where need[i]==0.

FSM:
- IDLE:
  - If any eligible: grant the first eligible index at or after rr_ptr (wrapping 3->0).
  - Latch the grant into sel, set req_id=sel, req_valid=1, go to REQ.
- REQ:
  - Hold req_valid and req_id stable until req_ack.
  - On req_ack: req_valid=0, beat counter=0, go to FILL.
- FILL:
  - in_ready=1.
  - On each in_valid&in_ready, next cycle: en/we[sel]=1, gbf_w_addr=counter, gbf_w_data=in_data (registered, 1-cycle write latency); counter++.
  - The beat with counter==GBF_DEPTH-1 is the last. After it, in_ready drops the next cycle; go to DONE.
  - in_valid low causes no write; the counter holds.
- DONE (1 cycle):
  - The last write is on the A-port this cycle.
  - Next cycle: buf_ready[sel] pulses 1 cycle; served[sel]=1; rr_ptr=sel+1 mod 4.
  - Avail: sel∈{0,1} sets gbf_actv_data_avail; sel∈{2,3} sets gbf_wgt_data_avail.
  - Return to IDLE.
- Only one fill in flight. Need changes during REQ/FILL do not change sel.
- Need deassert of sel during FILL: the fill still completes and ready still pulses.
- served prevents re-granting a buffer whose need is still high from the stale request. A served need must drop for ≥1 cycle before it is eligible again.
- Simultaneous need rise and served set on the same index: served wins.

finish==1 (any state, synchronous):
- Next cycle: state=IDLE, req_valid=0, in_ready=0, all en/we=0.
- No ready pulse; served=0; both avail=0; rr_ptr=0.
- A write registered in the same cycle as finish is still suppressed.
- Async reset mid-fill: immediate return to reset values; a partial fill leaves buffer contents undefined.
- Address never exceeds GBF_DEPTH-1; there is no wrap within a fill.

Test Plan:
- Single request: actv_gbf1_need_data=1, req_ack after 2 cycles, 32 back-to-back beats data=k -> req_id=0; actv_we1a high 32 cycles, addr 0..31, data k; gbf_actv_buf1_ready pulses once 2 cycles after last beat; gbf_actv_data_avail=1.
- Round-robin: all four needs high from reset, each held until its ready pulse -> grant order 0,1,2,3. Needs re-pulsed after dropping -> order continues from rr_ptr.
- Stalled stream: in_valid toggles 1,0,0,1 -> writes only on valid beats, addresses contiguous, exactly 32 writes, in_ready stays 1 until last beat.
- Stale need: wgt_gbf2_need_data held high after its ready pulse -> no second grant until it drops for ≥1 cycle and re-rises.
- finish at beat 10 of a wgt_gbf1 fill -> no further writes, no ready pulse, avail=0, IDLE; next request granted from index 0.
- reset asserted low mid-REQ -> req_valid=0 immediately; after release, the pending need is re-granted cleanly.
